platform_scroller: RTL and testbench
====================================

PLATFORM_SCROLLER -- requirements
Module: platform_scroller

Interface
REQ-001 SHALL have parameter NUM_PLAT, default 7, meaning the platform count (1..16).
REQ-002 SHALL have parameter POS_W, default 10, meaning the position width in bits.
REQ-003 SHALL have parameters HBP 325, HFP 625, VBP 31, VFP 511, meaning the screen left, right, top and bottom bounds.
REQ-004 SHALL have parameters FIRST_OFF 50, V_SPC 70, H_ALT 125, WIDTH 75, meaning the initial spacing, alternate x offset and platform width.
REQ-005 SHALL have parameters POWER_PROB 10 (power-up modulus) and RESUME_DLY 16 (resume delay, in cycles).
REQ-006 SHALL have port platform_clk, input, width 1: scroll clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-008 SHALL have port terminated, input, width 1: freeze request.
REQ-009 SHALL have port speed, input, width 3: scroll step in pixels per cycle; 0 holds position.
REQ-010 SHALL have ports new_hpos and power_rand_in, input, width POS_W: random x position and random power value.
REQ-011 SHALL have port consume_power, input, width NUM_PLAT: clears the power flag of platform i.
REQ-012 SHALL have ports vpos_flat and hpos_flat, output, width NUM_PLAT*POS_W: platform i occupies bits [i*POS_W +: POS_W].
REQ-013 SHALL have ports is_power and respawn_pulse, output, width NUM_PLAT: power flags and one-cycle wrap strobes.
REQ-014 SHALL have ports respawn_count (output, width 16) and state (output, width 2; RUN=0, FROZEN=1, RESUME=2).

Function
REQ-015 SHALL implement an FSM: RUN->FROZEN when terminated=1; FROZEN->RESUME when terminated=0; RESUME->RUN after RESUME_DLY cycles with terminated=0.
REQ-016 SHALL send RESUME back to FROZEN, with the delay counter reset to 0, if terminated rises during RESUME.
REQ-017 SHALL move platforms only in RUN; FROZEN and RESUME hold every position, flag and count (except per REQ-022).
REQ-018 In RUN, SHALL wrap a platform with vpos<=VBP to vpos=VFP-1; otherwise vpos <= max(vpos-speed, VBP), with no unsigned underflow.
REQ-019 On wrap, SHALL set hpos to new_hpos clamped to [HBP, HFP-WIDTH].
REQ-020 On wrap, SHALL set is_power[i] to (power_rand_in % POWER_PROB == 1), sampled that same cycle.
REQ-021 If several platforms wrap in the same cycle, all SHALL take the same new_hpos and power sample.
REQ-022 consume_power[i]=1 SHALL clear is_power[i] on the next edge in any state.
REQ-023 If a wrap and consume_power hit the same platform in the same cycle, the wrap result SHALL win.
REQ-024 respawn_pulse[i] SHALL be registered: high for exactly the one cycle after the edge that wrapped platform i.
REQ-025 respawn_count SHALL add the number of wraps in each cycle (popcount), saturating at 16'hFFFF.
REQ-026 SHALL have no combinational path from any input to any output.

Reset
REQ-027 On rst, vpos[i] SHALL be VBP+FIRST_OFF+i*V_SPC.
REQ-028 On rst, hpos[i] SHALL be HBP for even i and HBP+H_ALT for odd i.
REQ-029 On rst, is_power, respawn_pulse and respawn_count SHALL be 0, state SHALL be RUN, and the delay counter SHALL be 0.
REQ-030 rst asserted mid-operation SHALL override everything immediately, in any state.

Verification
REQ-031 Reset with defaults, speed=1, 20 cycles -> p0 vpos 81->61, p1 151->131, hpos 325/450 alternating, count=0.
REQ-032 Force p0 to vpos=31, new_hpos=600, power_rand_in=21 -> next edge: vpos=510, hpos=550 (clamped), is_power[0]=1, pulse[0]=1 for one cycle, count=1.
REQ-033 speed=7 with p0 at vpos=35 -> vpos=31, then wraps on the following edge; vpos never goes below 31.
REQ-034 terminated=1 for 5 cycles, then 0 -> positions frozen; state 0->1->2; RUN 16 cycles after release; terminated re-asserted at delay count 8 -> FROZEN, counter 0.
REQ-035 Wrap and consume_power[0] in the same cycle with power_rand_in=1 -> is_power[0]=1; consume next cycle -> 0.
REQ-036 NUM_PLAT=3, all forced to VBP, respawn_count preset to 16'hFFFE -> all three wrap in one cycle, count=16'hFFFF.

Source files
------------

// File: rtl/platform_scroller.sv
// Vertical platform scroller: NUM_PLAT platforms climb toward the top bound and
// respawn at the bottom with a random x position and power-up flag.
module platform_scroller #(
  parameter int NUM_PLAT   = 7,
  parameter int POS_W      = 10,
  parameter int HBP        = 325,
  parameter int HFP        = 625,
  parameter int VBP        = 31,
  parameter int VFP        = 511,
  parameter int FIRST_OFF  = 50,
  parameter int V_SPC      = 70,
  parameter int H_ALT      = 125,
  parameter int WIDTH      = 75,
  parameter int POWER_PROB = 10,
  parameter int RESUME_DLY = 16
) (
  input  logic                         platform_clk,
  input  logic                         rst,
  input  logic                         terminated,
  input  logic [2:0]                   speed,
  input  logic [POS_W-1:0]             new_hpos,
  input  logic [POS_W-1:0]             power_rand_in,
  input  logic [NUM_PLAT-1:0]          consume_power,
  output logic [NUM_PLAT*POS_W-1:0]    vpos_flat,
  output logic [NUM_PLAT*POS_W-1:0]    hpos_flat,
  output logic [NUM_PLAT-1:0]          is_power,
  output logic [NUM_PLAT-1:0]          respawn_pulse,
  output logic [15:0]                  respawn_count,
  output logic [1:0]                   state
);

  localparam int DLY_W = (RESUME_DLY > 1) ? $clog2(RESUME_DLY) : 1;
  localparam int CNT_W = $clog2(NUM_PLAT + 1);

  localparam logic [POS_W-1:0] V_TOP     = POS_W'(VBP);
  localparam logic [POS_W-1:0] V_RESPAWN = POS_W'(VFP - 1);
  localparam logic [POS_W-1:0] H_MIN     = POS_W'(HBP);
  localparam logic [POS_W-1:0] H_MAX     = POS_W'(HFP - WIDTH);
  localparam logic [DLY_W-1:0] DLY_LAST  = DLY_W'(RESUME_DLY - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FROZEN = 2'd1,
    ST_RESUME = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [DLY_W-1:0]            dly_q, dly_d;
  logic [NUM_PLAT*POS_W-1:0]   vpos_q, vpos_d;
  logic [NUM_PLAT*POS_W-1:0]   hpos_q, hpos_d;
  logic [NUM_PLAT-1:0]         pwr_q, pwr_d;
  logic [NUM_PLAT-1:0]         pulse_q;
  logic [NUM_PLAT-1:0]         wrap;
  logic [15:0]                 cnt_q, cnt_d;
  logic [CNT_W-1:0]            wrap_cnt;
  logic [16:0]                 cnt_sum;
  logic                        run_en;
  logic [POS_W-1:0]            hpos_new;
  logic                        power_new;
  logic [POS_W-1:0]            step;
  logic [POS_W-1:0]            cur;

  function automatic logic [NUM_PLAT*POS_W-1:0] vpos_init();
    logic [NUM_PLAT*POS_W-1:0] r;
    for (int i = 0; i < NUM_PLAT; i++) r[i*POS_W +: POS_W] = POS_W'(VBP + FIRST_OFF + i * V_SPC);
    return r;
  endfunction

  function automatic logic [NUM_PLAT*POS_W-1:0] hpos_init();
    logic [NUM_PLAT*POS_W-1:0] r;
    for (int i = 0; i < NUM_PLAT; i++) r[i*POS_W +: POS_W] = (i % 2 == 0) ? POS_W'(HBP) : POS_W'(HBP + H_ALT);
    return r;
  endfunction

  // FSM: state register (delay counter lives alongside it)
  always_ff @(posedge platform_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
    end
  end

  // FSM: next state; the delay counter is zero whenever we are not resuming
  always_comb begin
    state_d = state_q;
    dly_d   = '0;
    case (state_q)
      ST_RUN:    if (terminated) state_d = ST_FROZEN;
      ST_FROZEN: if (!terminated) state_d = ST_RESUME;
      ST_RESUME: begin
        if (terminated)             state_d = ST_FROZEN;
        else if (dly_q == DLY_LAST) state_d = ST_RUN;
        else                        dly_d   = dly_q + 1'b1;
      end
      default:   state_d = ST_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run_en = (state_q == ST_RUN);
    state  = state_q;
  end

  always_comb begin
    if (new_hpos < H_MIN)      hpos_new = H_MIN;
    else if (new_hpos > H_MAX) hpos_new = H_MAX;
    else                       hpos_new = new_hpos;
  end

  assign power_new = ((32'(power_rand_in) % POWER_PROB) == 1);
  assign step      = POS_W'(speed);

  // A wrap overrides a same-cycle consume because it is applied after the clear.
  always_comb begin
    vpos_d = vpos_q;
    hpos_d = hpos_q;
    pwr_d  = pwr_q & ~consume_power;
    wrap   = '0;
    cur    = '0;
    if (run_en) begin
      for (int i = 0; i < NUM_PLAT; i++) begin
        cur = vpos_q[i*POS_W +: POS_W];
        if (cur <= V_TOP) begin
          wrap[i]                  = 1'b1;
          vpos_d[i*POS_W +: POS_W] = V_RESPAWN;
          hpos_d[i*POS_W +: POS_W] = hpos_new;
          pwr_d[i]                 = power_new;
        end else if (cur - V_TOP <= step) begin
          vpos_d[i*POS_W +: POS_W] = V_TOP;
        end else begin
          vpos_d[i*POS_W +: POS_W] = cur - step;
        end
      end
    end
  end

  always_comb begin
    wrap_cnt = '0;
    for (int i = 0; i < NUM_PLAT; i++) wrap_cnt = wrap_cnt + CNT_W'(wrap[i]);
  end

  assign cnt_sum = {1'b0, cnt_q} + 17'(wrap_cnt);
  assign cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  always_ff @(posedge platform_clk or posedge rst) begin
    if (rst) begin
      vpos_q  <= vpos_init();
      hpos_q  <= hpos_init();
      pwr_q   <= '0;
      pulse_q <= '0;
      cnt_q   <= '0;
    end else begin
      vpos_q  <= vpos_d;
      hpos_q  <= hpos_d;
      pwr_q   <= pwr_d;
      pulse_q <= wrap;
      cnt_q   <= cnt_d;
    end
  end

  assign vpos_flat     = vpos_q;
  assign hpos_flat     = hpos_q;
  assign is_power      = pwr_q;
  assign respawn_pulse = pulse_q;
  assign respawn_count = cnt_q;

endmodule

// File: tb/tb_platform_scroller.sv
// Directed bench for platform_scroller: a table of hand-computed vectors on the
// default configuration plus a three-platform instance for simultaneous wraps.
module tb_platform_scroller;

  localparam int NP = 7;
  localparam int PW = 10;

  typedef struct {
    logic          term;
    logic [2:0]    spd;
    logic [PW-1:0] nh;
    logic [PW-1:0] pr;
    logic [NP-1:0] cons;
    int            n;
    logic [1:0]    st;
    logic [PW-1:0] p0v;
    logic [PW-1:0] p0h;
    logic [PW-1:0] p1v;
    logic [PW-1:0] p1h;
    logic [NP-1:0] pwr;
    logic [NP-1:0] pulse;
    logic [15:0]   cnt;
  } vec_t;

  logic              clk;
  logic              rst, rst3;
  logic              term, term3;
  logic [2:0]        spd, spd3;
  logic [PW-1:0]     nh, pr, nh3, pr3;
  logic [NP-1:0]     cons;
  logic [2:0]        cons3;
  logic [NP*PW-1:0]  vpos, hpos;
  logic [NP-1:0]     pwr, pulse;
  logic [15:0]       cnt, cnt3;
  logic [1:0]        st, st3;
  logic [3*PW-1:0]   vpos3, hpos3;
  logic [2:0]        pwr3, pulse3;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];
  logic [15:0] exp_q[$];

  platform_scroller dut (
    .platform_clk(clk), .rst(rst), .terminated(term), .speed(spd),
    .new_hpos(nh), .power_rand_in(pr), .consume_power(cons),
    .vpos_flat(vpos), .hpos_flat(hpos), .is_power(pwr), .respawn_pulse(pulse),
    .respawn_count(cnt), .state(st)
  );

  // Respawn row equals the top bound, so all three platforms wrap on every edge.
  platform_scroller #(.NUM_PLAT(3), .VFP(32), .FIRST_OFF(0), .V_SPC(0)) dut3 (
    .platform_clk(clk), .rst(rst3), .terminated(term3), .speed(spd3),
    .new_hpos(nh3), .power_rand_in(pr3), .consume_power(cons3),
    .vpos_flat(vpos3), .hpos_flat(hpos3), .is_power(pwr3), .respawn_pulse(pulse3),
    .respawn_count(cnt3), .state(st3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic t, input logic [2:0] s, input logic [PW-1:0] h,
                              input logic [PW-1:0] p, input logic [NP-1:0] c, input int n,
                              input logic [1:0] es, input logic [PW-1:0] v0, input logic [PW-1:0] h0,
                              input logic [PW-1:0] v1, input logic [PW-1:0] h1,
                              input logic [NP-1:0] ep, input logic [NP-1:0] eu, input logic [15:0] ec);
    vec_t v;
    v.term = t; v.spd = s; v.nh = h; v.pr = p; v.cons = c; v.n = n;
    v.st = es; v.p0v = v0; v.p0h = h0; v.p1v = v1; v.p1h = h1;
    v.pwr = ep; v.pulse = eu; v.cnt = ec;
    vecs.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    term = 1'b0; spd = 3'd0; nh = '0; pr = '0; cons = '0;
    term3 = 1'b0; spd3 = 3'd0; nh3 = '0; pr3 = '0; cons3 = '0;

    //   term spd  nh   pr  cons  n | st  p0v  p0h  p1v  p1h  pwr    pulse  cnt
    add(0, 1,   0,  0, 7'h00, 20,  0,  61, 325, 131, 450, 7'h00, 7'h00, 0);
    add(1, 1,   0,  0, 7'h00,  1,  1,  60, 325, 130, 450, 7'h00, 7'h00, 0);
    add(1, 1,   0,  0, 7'h00,  4,  1,  60, 325, 130, 450, 7'h00, 7'h00, 0);
    add(0, 1,   0,  0, 7'h00,  1,  2,  60, 325, 130, 450, 7'h00, 7'h00, 0);
    add(0, 1,   0,  0, 7'h00, 15,  2,  60, 325, 130, 450, 7'h00, 7'h00, 0);
    add(0, 1,   0,  0, 7'h00,  1,  0,  60, 325, 130, 450, 7'h00, 7'h00, 0);
    add(0, 1,   0,  0, 7'h00,  1,  0,  59, 325, 129, 450, 7'h00, 7'h00, 0);
    add(1, 1,   0,  0, 7'h00,  1,  1,  58, 325, 128, 450, 7'h00, 7'h00, 0);
    add(0, 1,   0,  0, 7'h00,  1,  2,  58, 325, 128, 450, 7'h00, 7'h00, 0);
    add(0, 1,   0,  0, 7'h00,  8,  2,  58, 325, 128, 450, 7'h00, 7'h00, 0);
    add(1, 1,   0,  0, 7'h00,  1,  1,  58, 325, 128, 450, 7'h00, 7'h00, 0);
    add(0, 1,   0,  0, 7'h00,  1,  2,  58, 325, 128, 450, 7'h00, 7'h00, 0);
    add(0, 1,   0,  0, 7'h00, 15,  2,  58, 325, 128, 450, 7'h00, 7'h00, 0);
    add(0, 1,   0,  0, 7'h00,  1,  0,  58, 325, 128, 450, 7'h00, 7'h00, 0);
    add(0, 1,   0,  0, 7'h00, 27,  0,  31, 325, 101, 450, 7'h00, 7'h00, 0);
    add(0, 1, 600, 21, 7'h00,  1,  0, 510, 550, 100, 450, 7'h01, 7'h01, 1);
    add(0, 1, 400,  0, 7'h00,  1,  0, 509, 550,  99, 450, 7'h01, 7'h00, 1);
    add(0, 1, 400,  0, 7'h00, 68,  0, 441, 550,  31, 450, 7'h01, 7'h00, 1);
    add(0, 1, 100,  1, 7'h02,  1,  0, 440, 550, 510, 325, 7'h03, 7'h02, 2);
    add(0, 1, 100,  0, 7'h02,  1,  0, 439, 550, 509, 325, 7'h01, 7'h00, 2);
    add(0, 5, 200,  0, 7'h00,  1,  0, 434, 550, 504, 325, 7'h01, 7'h00, 2);
    add(0, 7, 200,  0, 7'h00, 57,  0,  35, 550, 105, 325, 7'h01, 7'h00, 7);
    add(0, 7,   0,  5, 7'h00,  1,  0,  31, 550,  98, 325, 7'h01, 7'h00, 7);
    add(0, 7,   0,  5, 7'h00,  1,  0, 510, 325,  91, 325, 7'h00, 7'h01, 8);
    add(0, 0,   0,  5, 7'h00,  3,  0, 510, 325,  91, 325, 7'h00, 7'h00, 8);
    add(1, 0,   0,  0, 7'h00,  1,  1, 510, 325,  91, 325, 7'h00, 7'h00, 8);

    step(2);
    chk("rst_state", st, 0);
    chk("rst_p0v", vpos[0*PW +: PW], 81);
    chk("rst_p1v", vpos[1*PW +: PW], 151);
    chk("rst_p6v", vpos[6*PW +: PW], 501);
    chk("rst_p0h", hpos[0*PW +: PW], 325);
    chk("rst_p1h", hpos[1*PW +: PW], 450);
    chk("rst_p6h", hpos[6*PW +: PW], 325);
    chk("rst_pwr", pwr, 0);
    chk("rst_pulse", pulse, 0);
    chk("rst_cnt", cnt, 0);
    rst = 1'b0;

    for (int r = 0; r < vecs.size(); r++) begin
      term = vecs[r].term; spd = vecs[r].spd; nh = vecs[r].nh;
      pr = vecs[r].pr; cons = vecs[r].cons;
      step(vecs[r].n);
      chk($sformatf("row%0d_state", r), st, vecs[r].st);
      chk($sformatf("row%0d_p0v", r), vpos[0*PW +: PW], vecs[r].p0v);
      chk($sformatf("row%0d_p0h", r), hpos[0*PW +: PW], vecs[r].p0h);
      chk($sformatf("row%0d_p1v", r), vpos[1*PW +: PW], vecs[r].p1v);
      chk($sformatf("row%0d_p1h", r), hpos[1*PW +: PW], vecs[r].p1h);
      chk($sformatf("row%0d_pwr", r), pwr, vecs[r].pwr);
      chk($sformatf("row%0d_pulse", r), pulse, vecs[r].pulse);
      chk($sformatf("row%0d_cnt", r), cnt, vecs[r].cnt);
    end

    // Asynchronous reset while frozen, observed before the next clock edge
    #2 rst = 1'b1;
    #1;
    chk("arst_state", st, 0);
    chk("arst_p0v", vpos[0*PW +: PW], 81);
    chk("arst_p0h", hpos[0*PW +: PW], 325);
    chk("arst_p1v", vpos[1*PW +: PW], 151);
    chk("arst_cnt", cnt, 0);
    term = 1'b0;
    step(1);
    rst = 1'b0;

    // Three-platform instance: +3 per edge until the count saturates
    @(posedge clk); #1;
    rst3 = 1'b0; spd3 = 3'd1; nh3 = 10'd700; pr3 = 10'd31;
    chk("p3_start_cnt", cnt3, 0);
    chk("p3_start_vpos", vpos3, {3{10'd31}});
    exp_q.push_back(16'd65532);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'hFFFF);

    step(21844);
    chk("p3_cnt_a", cnt3, exp_q.pop_front());
    chk("p3_vpos_a", vpos3, {3{10'd31}});
    chk("p3_hpos_a", hpos3, {3{10'd550}});
    chk("p3_pwr_a", pwr3, 3'b111);
    chk("p3_pulse_a", pulse3, 3'b111);

    nh3 = 10'd400; pr3 = 10'd2;
    step(1);
    chk("p3_cnt_b", cnt3, exp_q.pop_front());
    chk("p3_hpos_b", hpos3, {3{10'd400}});
    chk("p3_pwr_b", pwr3, 3'b000);
    chk("p3_pulse_b", pulse3, 3'b111);

    step(1);
    chk("p3_cnt_sat", cnt3, exp_q.pop_front());
    chk("p3_state", st3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
